axis_probe_initiator: RTL and testbench

On-chip initiator for the probe packet protocol, on the host end of the AXI-Stream link. It serialises a wide vip2dut request word into a C_DATA_WIDTH beat packet on its master port. It then collects the probe's dut2vip reply packet on its slave port and presents the reassembled word with status flags. Uses: FPGA-side self-test of the probe/DUT path without the XDMA host, and a bench-side driver for the probe.

---
 rtl/axis_probe_initiator.sv | 220 ++++++++++++++++++++++
 tb/tb_axis_probe_initiator.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_probe_initiator.sv
// axis_probe_initiator
// Host-side initiator for the probe packet protocol. A wide request word is
// serialised into a fixed-length AXI-Stream packet on the master port. The
// reply packet is then collected from the slave port and reassembled into a
// wide response word. The response carries a framing-error flag and a
// timeout flag.
module axis_probe_initiator #(
    parameter int C_DATA_WIDTH      = 128,
    parameter int VIP2DUT_WORDS_NUM = 1,
    parameter int DUT2VIP_WORDS_NUM = 1,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                                        s_axis_aclk,
    input  logic                                        s_axis_aresetn,

    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic [C_DATA_WIDTH*VIP2DUT_WORDS_NUM-1:0]   cmd_data,

    output logic                                        m_axis_tvalid,
    input  logic                                        m_axis_tready,
    output logic [C_DATA_WIDTH-1:0]                     m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]                   m_axis_tkeep,
    output logic                                        m_axis_tlast,

    input  logic                                        s_axis_tvalid,
    output logic                                        s_axis_tready,
    input  logic [C_DATA_WIDTH-1:0]                     s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]                   s_axis_tkeep,
    input  logic                                        s_axis_tlast,

    output logic                                        rsp_valid,
    input  logic                                        rsp_ready,
    output logic [C_DATA_WIDTH*DUT2VIP_WORDS_NUM-1:0]   rsp_data,
    output logic                                        rsp_error,
    output logic                                        rsp_timeout
);

    localparam int KEEP_W    = C_DATA_WIDTH / 8;
    localparam int REQ_W     = C_DATA_WIDTH * VIP2DUT_WORDS_NUM;
    localparam int RSP_W     = C_DATA_WIDTH * DUT2VIP_WORDS_NUM;
    localparam int MAX_WORDS = (VIP2DUT_WORDS_NUM > DUT2VIP_WORDS_NUM) ?
                               VIP2DUT_WORDS_NUM : DUT2VIP_WORDS_NUM;
    localparam int CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND  = 3'd1,
        RECV  = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t             state;
    logic [REQ_W-1:0]   cmd_buf;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   next_cnt;
    logic [31:0]        tmo_cnt;
    logic               s_beat;
    logic               tmo_hit;

    // Select request word idx out of the latched command.
    function automatic logic [C_DATA_WIDTH-1:0] req_word(
        input logic [REQ_W-1:0] buf_in,
        input logic [CNT_W-1:0] idx
    );
        logic [C_DATA_WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < VIP2DUT_WORDS_NUM; i++) begin
            if (idx == CNT_W'(i)) begin
                w = buf_in[i*C_DATA_WIDTH +: C_DATA_WIDTH];
            end
        end
        return w;
    endfunction

    // Return the response word with slot idx replaced by a new beat.
    function automatic logic [RSP_W-1:0] put_word(
        input logic [RSP_W-1:0]        cur,
        input logic [CNT_W-1:0]        idx,
        input logic [C_DATA_WIDTH-1:0] w
    );
        logic [RSP_W-1:0] r;
        r = cur;
        for (int i = 0; i < DUT2VIP_WORDS_NUM; i++) begin
            if (idx == CNT_W'(i)) begin
                r[i*C_DATA_WIDTH +: C_DATA_WIDTH] = w;
            end
        end
        return r;
    endfunction

    assign next_cnt     = cnt + 1'b1;
    assign s_beat       = s_axis_tvalid & s_axis_tready;
    // The limit is reached when this idle cycle would bring the count to TIMEOUT_CYCLES.
    assign tmo_hit      = (TIMEOUT_CYCLES != 0) &&
                          (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign m_axis_tkeep = {KEEP_W{m_axis_tvalid}};

    // Transaction FSM: request serialisation, response collection and hand-off.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state         <= IDLE;
            cmd_buf       <= '0;
            cnt           <= '0;
            tmo_cnt       <= '0;
            cmd_ready     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            s_axis_tready <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_error     <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_buf       <= cmd_data;
                        cnt           <= '0;
                        cmd_ready     <= 1'b0;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= cmd_data[C_DATA_WIDTH-1:0];
                        m_axis_tlast  <= (VIP2DUT_WORDS_NUM == 1);
                        state         <= SEND;
                    end else begin
                        cmd_ready     <= 1'b1;
                    end
                end

                SEND: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (m_axis_tlast) begin
                            // Request done: open a fresh response window.
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tdata  <= '0;
                            cnt           <= '0;
                            tmo_cnt       <= '0;
                            rsp_data      <= '0;
                            rsp_error     <= 1'b0;
                            rsp_timeout   <= 1'b0;
                            s_axis_tready <= 1'b1;
                            state         <= RECV;
                        end else begin
                            cnt           <= next_cnt;
                            m_axis_tdata  <= req_word(cmd_buf, next_cnt);
                            m_axis_tlast  <= (next_cnt == CNT_W'(VIP2DUT_WORDS_NUM - 1));
                        end
                    end
                end

                RECV: begin
                    if (s_beat) begin
                        tmo_cnt  <= '0;
                        rsp_data <= put_word(rsp_data, cnt, s_axis_tdata);
                        if (s_axis_tkeep != {KEEP_W{1'b1}}) begin
                            rsp_error <= 1'b1;
                        end
                        if (s_axis_tlast) begin
                            // Early tlast leaves the remaining slots at zero.
                            if (cnt != CNT_W'(DUT2VIP_WORDS_NUM - 1)) begin
                                rsp_error <= 1'b1;
                            end
                            s_axis_tready <= 1'b0;
                            rsp_valid     <= 1'b1;
                            state         <= RESP;
                        end else if (cnt == CNT_W'(DUT2VIP_WORDS_NUM - 1)) begin
                            // Packet overruns the response word: discard the rest.
                            rsp_error <= 1'b1;
                            state     <= DRAIN;
                        end else begin
                            cnt <= next_cnt;
                        end
                    end else if (tmo_hit) begin
                        rsp_timeout   <= 1'b1;
                        s_axis_tready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        state         <= RESP;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                DRAIN: begin
                    if (s_beat) begin
                        tmo_cnt <= '0;
                        if (s_axis_tlast) begin
                            s_axis_tready <= 1'b0;
                            rsp_valid     <= 1'b1;
                            state         <= RESP;
                        end
                    end else if (tmo_hit) begin
                        rsp_timeout   <= 1'b1;
                        s_axis_tready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        state         <= RESP;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                RESP: begin
                    // Response fields stay put after hand-off until the next RECV entry.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_probe_initiator.sv
// Testbench for axis_probe_initiator: directed protocol scenarios plus
// randomized transactions checked against a packet-level reference model.
module tb_axis_probe_initiator;

    localparam int W   = 128;
    localparam int NV  = 2;
    localparam int ND  = 2;
    localparam int TMO = 16;
    localparam int KW  = W / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic            cmd_valid, cmd_ready;
    logic [NV*W-1:0] cmd_data;
    logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [W-1:0]    m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [W-1:0]    s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic            rsp_valid, rsp_ready, rsp_error, rsp_timeout;
    logic [ND*W-1:0] rsp_data;

    // Second instance with the timeout disabled.
    logic            z_cmd_valid, z_cmd_ready;
    logic [NV*W-1:0] z_cmd_data;
    logic            z_m_tvalid, z_m_tready, z_m_tlast;
    logic [W-1:0]    z_m_tdata;
    logic [KW-1:0]   z_m_tkeep;
    logic            z_s_tvalid, z_s_tready, z_s_tlast;
    logic [W-1:0]    z_s_tdata;
    logic [KW-1:0]   z_s_tkeep;
    logic            z_rsp_valid, z_rsp_ready, z_rsp_error, z_rsp_timeout;
    logic [ND*W-1:0] z_rsp_data;

    axis_probe_initiator #(
        .C_DATA_WIDTH(W), .VIP2DUT_WORDS_NUM(NV),
        .DUT2VIP_WORDS_NUM(ND), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout)
    );

    axis_probe_initiator #(
        .C_DATA_WIDTH(W), .VIP2DUT_WORDS_NUM(NV),
        .DUT2VIP_WORDS_NUM(ND), .TIMEOUT_CYCLES(0)
    ) dut_notmo (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready), .cmd_data(z_cmd_data),
        .m_axis_tvalid(z_m_tvalid), .m_axis_tready(z_m_tready),
        .m_axis_tdata(z_m_tdata), .m_axis_tkeep(z_m_tkeep), .m_axis_tlast(z_m_tlast),
        .s_axis_tvalid(z_s_tvalid), .s_axis_tready(z_s_tready),
        .s_axis_tdata(z_s_tdata), .s_axis_tkeep(z_s_tkeep), .s_axis_tlast(z_s_tlast),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_data(z_rsp_data),
        .rsp_error(z_rsp_error), .rsp_timeout(z_rsp_timeout)
    );

    int errors = 0;
    int checks = 0;
    int tr_mode;   // 0: always ready, 1: pattern 1,0,0,1, 2: random

    // Response packet to be played back by the probe side.
    logic [W-1:0]  bq_data[$];
    logic [KW-1:0] bq_keep[$];
    bit            bq_last[$];
    int            bq_gap[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_beats();
        bq_data.delete(); bq_keep.delete(); bq_last.delete(); bq_gap.delete();
    endtask

    task automatic add_beat(input logic [W-1:0] d, input logic [KW-1:0] k,
                            input bit l, input int g);
        bq_data.push_back(d); bq_keep.push_back(k);
        bq_last.push_back(l); bq_gap.push_back(g);
    endtask

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Packet-level view: the packet ends at the first tlast; the response
    // holds its first ND beats; framing is wrong unless exactly ND beats end
    // with tlast; a short packet without tlast is not a framing error.
    function automatic void model(output logic [ND*W-1:0] d, output logic err);
        int len;
        bit found;
        len   = bq_data.size();
        found = 0;
        for (int i = 0; i < bq_data.size(); i++) begin
            if (!found && bq_last[i]) begin
                found = 1;
                len   = i + 1;
            end
        end
        d   = '0;
        err = found ? (len != ND) : (len >= ND);
        for (int i = 0; i < len && i < ND; i++) begin
            d[i*W +: W] = bq_data[i];
            if (bq_keep[i] != {KW{1'b1}}) err = 1'b1;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"},   256'(cmd_ready),     256'(0));
        chk({tag, "_m_tvalid"},    256'(m_axis_tvalid), 256'(0));
        chk({tag, "_m_tlast"},     256'(m_axis_tlast),  256'(0));
        chk({tag, "_m_tdata"},     256'(m_axis_tdata),  256'(0));
        chk({tag, "_m_tkeep"},     256'(m_axis_tkeep),  256'(0));
        chk({tag, "_s_tready"},    256'(s_axis_tready), 256'(0));
        chk({tag, "_rsp_valid"},   256'(rsp_valid),     256'(0));
        chk({tag, "_rsp_error"},   256'(rsp_error),     256'(0));
        chk({tag, "_rsp_timeout"}, 256'(rsp_timeout),   256'(0));
        chk({tag, "_rsp_data"},    256'(rsp_data),      256'(0));
    endtask

    // One full transaction; called and returning on a falling clock edge.
    task automatic run_txn(input logic [NV*W-1:0] cmd, input int hold, input bit expect_tmo);
        logic [ND*W-1:0] exp_d;
        logic            exp_e;
        int              n;
        int              k;
        bit              tr;
        model(exp_d, exp_e);

        cmd_data  = cmd;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("cmd_accept", 256'(cmd_ready), 256'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_to_tvalid", 256'(m_axis_tvalid), 256'(1));
        chk("cmd_ready_busy", 256'(cmd_ready), 256'(0));

        k = 0; n = 0;
        while (k < NV && n < 100) begin
            case (tr_mode)
                0:       tr = 1'b1;
                1:       tr = (n % 4 == 0) || (n % 4 == 3);
                default: tr = 1'($urandom_range(0, 1));
            endcase
            m_axis_tready = tr;
            chk("m_tvalid", 256'(m_axis_tvalid), 256'(1));
            chk("m_tdata",  256'(m_axis_tdata),  256'(cmd[k*W +: W]));
            chk("m_tlast",  256'(m_axis_tlast),  256'(k == NV - 1));
            chk("m_tkeep",  256'(m_axis_tkeep),  256'({KW{1'b1}}));
            if (tr) k++;
            @(negedge clk);
            n++;
        end
        m_axis_tready = 1'b0;
        chk("m_beat_count", 256'(k), 256'(NV));
        chk("m_idle_after", 256'(m_axis_tvalid), 256'(0));
        chk("s_tready_recv", 256'(s_axis_tready), 256'(1));

        for (int i = 0; i < bq_data.size(); i++) begin
            s_axis_tvalid = 1'b0;
            repeat (bq_gap[i]) @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = bq_data[i];
            s_axis_tkeep  = bq_keep[i];
            s_axis_tlast  = bq_last[i];
            n = 0;
            while (s_axis_tready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            chk("s_beat_accept", 256'(s_axis_tready), 256'(1));
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;

        n = 1;
        while (rsp_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        if (expect_tmo) chk("tmo_latency", 256'(n), 256'(TMO + 1));
        else            chk("rsp_latency", 256'(n), 256'(1));
        chk("rsp_data",    256'(rsp_data),    256'(exp_d));
        chk("rsp_error",   256'(rsp_error),   256'(exp_e));
        chk("rsp_timeout", 256'(rsp_timeout), 256'(expect_tmo));
        chk("s_tready_resp", 256'(s_axis_tready), 256'(0));

        rsp_ready = 1'b0;
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            chk("rsp_hold_valid", 256'(rsp_valid), 256'(1));
            chk("rsp_hold_data",  256'(rsp_data),  256'(exp_d));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop",        256'(rsp_valid),     256'(0));
        chk("rsp_data_kept",   256'(rsp_data),      256'(exp_d));
        chk("rsp_error_kept",  256'(rsp_error),     256'(exp_e));
        chk("rsp_tmo_kept",    256'(rsp_timeout),   256'(expect_tmo));
        chk("idle_cmd_ready",  256'(cmd_ready),     256'(1));
        chk("idle_s_tready",   256'(s_axis_tready), 256'(0));
    endtask

    initial begin
        int n;
        logic [NV*W-1:0] c;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_data = '0; m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        rsp_ready = 1'b0;
        z_cmd_valid = 1'b0; z_cmd_data = '0; z_m_tready = 1'b1;
        z_s_tvalid = 1'b0; z_s_tdata = '0; z_s_tkeep = '0; z_s_tlast = 1'b0;
        z_rsp_ready = 1'b0;
        tr_mode = 0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal loopback.
        clear_beats();
        add_beat(128'h1, '1, 1'b0, 0);
        add_beat(128'h2, '1, 1'b1, 0);
        run_txn({128'hB, 128'hA}, 1, 1'b0);

        // Backpressure on both request stream and response hand-off.
        tr_mode = 1;
        clear_beats();
        add_beat(128'h11, '1, 1'b0, 2);
        add_beat(128'h22, '1, 1'b1, 3);
        run_txn({128'hBB, 128'hAA}, 5, 1'b0);
        tr_mode = 0;

        // Early tlast.
        clear_beats();
        add_beat(128'h7, '1, 1'b1, 0);
        run_txn({128'h6, 128'h5}, 1, 1'b0);

        // Missing tlast: third beat drained.
        clear_beats();
        add_beat(128'h31, '1, 1'b0, 0);
        add_beat(128'h32, '1, 1'b0, 1);
        add_beat(128'h33, '1, 1'b1, 0);
        run_txn({128'h3B, 128'h3A}, 2, 1'b0);

        // Partial tkeep is flagged but stored.
        clear_beats();
        add_beat(128'h41, '1, 1'b0, 0);
        add_beat(128'h42, 16'h0FFF, 1'b1, 0);
        run_txn({128'h4B, 128'h4A}, 1, 1'b0);

        // No response at all.
        clear_beats();
        run_txn({128'h5B, 128'h5A}, 2, 1'b1);

        // Final beat lands on the cycle the timeout limit would be reached.
        clear_beats();
        add_beat(128'h61, '1, 1'b0, 0);
        add_beat(128'h62, '1, 1'b1, TMO - 1);
        run_txn({128'h6B, 128'h6A}, 1, 1'b0);

        // Randomized transactions.
        tr_mode = 2;
        for (int t = 0; t < 20; t++) begin
            int shape;
            clear_beats();
            shape = $urandom_range(0, 3);
            if (shape == 2) begin
                add_beat(rnd_word(), ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'hFFFF, 1'b1,
                         $urandom_range(0, 3));
            end else begin
                int nb;
                nb = (shape == 3) ? 3 : 2;
                for (int b = 0; b < nb; b++) begin
                    add_beat(rnd_word(), ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'hFFFF,
                             b == nb - 1, $urandom_range(0, 3));
                end
            end
            c = {rnd_word(), rnd_word()};
            run_txn(c, $urandom_range(1, 6), 1'b0);
        end
        tr_mode = 0;

        // Reset in the middle of the request packet.
        cmd_data  = {128'hD2, 128'hD1};
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("rst_cmd_accept", 256'(cmd_ready), 256'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        m_axis_tready = 1'b0;
        chk("rst_mid_beat1", 256'(m_axis_tdata), 256'(128'hD2));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_beats();
        add_beat(128'hE5, '1, 1'b0, 0);
        add_beat(128'hE6, '1, 1'b1, 1);
        run_txn({128'hE2, 128'hE1}, 1, 1'b0);

        // Timeout disabled: the second instance must wait indefinitely.
        z_cmd_data  = {128'hF2, 128'hF1};
        z_cmd_valid = 1'b1;
        n = 0;
        while (z_cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("notmo_cmd_accept", 256'(z_cmd_ready), 256'(1));
        @(negedge clk);
        z_cmd_valid = 1'b0;
        repeat (200) @(negedge clk);
        chk("notmo_rsp_valid",   256'(z_rsp_valid),   256'(0));
        chk("notmo_rsp_timeout", 256'(z_rsp_timeout), 256'(0));
        chk("notmo_s_tready",    256'(z_s_tready),    256'(1));
        chk("notmo_m_tvalid",    256'(z_m_tvalid),    256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
